// File: rtl/udp_sched_pkg.sv
// Shared types and helpers for the UDP stream scheduler: FSM encoding,
// framing constants and the payload-bytes-to-words conversion.
package udp_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } sched_state_e;

   localparam int IP_UDP_HDR_BYTES = 28;
   localparam int JUMBO_MTU        = 9000;
   localparam int WCNT_W           = 15;

   // 17-bit sum so a 0xFFFF length rounds up instead of wrapping.
   function automatic logic [WCNT_W-1:0] word_count(input logic [15:0] len);
      logic [16:0] sum;
      sum = {1'b0, len} + 17'd3;
      return sum[16:2];
   endfunction

endpackage

// File: rtl/udp_stream_scheduler_if.sv
// Source-side and framer-side handshake bundle of the scheduler; slave is the
// scheduler, master is whatever drives the sources and the framer ready.
interface udp_stream_scheduler_if #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_SRC-1:0]            src_req;
   logic [NUM_SRC*16-1:0]         src_len;
   logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
   logic [NUM_SRC-1:0]            src_valid;
   logic [NUM_SRC-1:0]            src_ready;
   logic [NUM_SRC-1:0]            src_grant;
   logic [DATA_WIDTH-1:0]         stk_data;
   logic [15:0]                   stk_len;
   logic [15:0]                   stk_dst_port;
   logic                          stk_valid;
   logic                          stk_ready;

   modport master (
      output src_req, src_len, src_data, src_valid, stk_ready,
      input  src_ready, src_grant, stk_data, stk_len, stk_dst_port, stk_valid
   );

   modport slave (
      input  src_req, src_len, src_data, src_valid, stk_ready,
      output src_ready, src_grant, stk_data, stk_len, stk_dst_port, stk_valid
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority encoder: searches req&mask starting at
// ptr+1 and wrapping; zero latency, no backpressure of its own.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic [N-1:0] mask,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);

   always_comb begin
      int c;
      c   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 1; k <= N; k++) begin
         c = (int'(ptr) + k) % N;
         if (!any && req[c] && mask[c]) begin
            gnt[c] = 1'b1;
            idx    = W'(c);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/udp_stream_scheduler.sv
// Packet arbiter for the UDP framer: 1-cycle request-to-grant, words pass through combinationally,
// stk_ready backpressures the granted source; STRICT_PRIO_EN gives source 0 strict priority.
module udp_stream_scheduler
   import udp_sched_pkg::*;
#(
   parameter int          NUM_SRC    = 4,
   parameter int          DATA_WIDTH = 32,
   parameter logic [15:0] BASE_PORT  = 16'd5000,
   parameter logic [15:0] MAX_LEN    = 16'(JUMBO_MTU - IP_UDP_HDR_BYTES),
   parameter int          GAP_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   udp_stream_scheduler_if.slave bus,
   output logic                  pkt_done,
   output logic                  err_len,
   input  logic                  err_clr,
   output logic [31:0]           pkt_count
);

   localparam int PTR_W = $clog2(NUM_SRC);

   sched_state_e       state_q, state_d;
   logic [PTR_W-1:0]   sel_q, sel_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WCNT_W-1:0]  words_q, words_d;
   logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
   logic [3:0]         gap_q, gap_d;
   logic [15:0]        len_q, len_d;
   logic [15:0]        port_q, port_d;
   logic [NUM_SRC-1:0] grant_q, grant_d;
   logic               err_q, err_d;
   logic [31:0]        cnt_q, cnt_d;

   logic [NUM_SRC-1:0] arb_mask, arb_gnt;
   logic [PTR_W-1:0]   arb_idx, win_idx;
   logic               arb_any, win_any, win_upd;
   logic [15:0]        win_len;
   logic               cur_valid, xfer;

   rr_arbiter #(.N(NUM_SRC), .W(PTR_W)) u_arb (
      .req  (bus.src_req),
      .ptr  (rr_ptr_q),
      .mask (arb_mask),
      .gnt  (arb_gnt),
      .idx  (arb_idx),
      .any  (arb_any)
   );

`ifdef STRICT_PRIO_EN
   // Source 0 bypasses the rotation and never moves the pointer.
   assign arb_mask = {{(NUM_SRC-1){1'b1}}, 1'b0};
   always_comb begin
      win_idx = arb_idx;
      win_any = arb_any;
      win_upd = 1'b1;
      if (bus.src_req[0]) begin
         win_idx = '0;
         win_any = 1'b1;
         win_upd = 1'b0;
      end
   end
`else
   assign arb_mask = '1;
   always_comb begin
      win_idx = arb_idx;
      win_any = arb_any;
      win_upd = 1'b1;
   end
`endif

   assign win_len   = bus.src_len[int'(win_idx)*16 +: 16];
   assign cur_valid = (state_q == SEND) && bus.src_valid[sel_q];
   assign xfer      = cur_valid && bus.stk_ready;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;
      words_d  = words_q;
      wcnt_d   = wcnt_q;
      gap_d    = gap_q;
      len_d    = len_q;
      port_d   = port_q;
      grant_d  = grant_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      pkt_done = 1'b0;
      if (err_clr) err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               len_d   = win_len;
               port_d  = BASE_PORT + 16'(win_idx);
               words_d = word_count(win_len);
               wcnt_d  = '0;
               sel_d   = win_idx;
               if (win_upd) rr_ptr_d = win_idx;
               if (win_len != 16'd0 && win_len <= MAX_LEN) begin
                  state_d = SEND;
                  grant_d = NUM_SRC'(1) << win_idx;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SEND: begin
            if (xfer) begin
               wcnt_d = wcnt_q + WCNT_W'(1);
               if (wcnt_q == words_q - WCNT_W'(1)) begin
                  pkt_done = 1'b1;
                  cnt_d    = cnt_q + 32'd1;
                  grant_d  = '0;
                  gap_d    = 4'(GAP_CYCLES);
                  state_d  = GAP;
               end
            end
         end
         GAP: begin
            gap_d = gap_q - 4'd1;
            if (gap_q == 4'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         rr_ptr_q <= '0;
         words_q  <= '0;
         wcnt_q   <= '0;
         gap_q    <= '0;
         len_q    <= '0;
         port_q   <= BASE_PORT;
         grant_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         rr_ptr_q <= rr_ptr_d;
         words_q  <= words_d;
         wcnt_q   <= wcnt_d;
         gap_q    <= gap_d;
         len_q    <= len_d;
         port_q   <= port_d;
         grant_q  <= grant_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.src_grant    = grant_q;
   assign bus.src_ready    = (state_q == SEND) ? (grant_q & {NUM_SRC{bus.stk_ready}}) : '0;
   assign bus.stk_data     = (state_q == SEND) ? bus.src_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign bus.stk_valid    = cur_valid;
   assign bus.stk_len      = len_q;
   assign bus.stk_dst_port = port_q;
   assign err_len          = err_q;
   assign pkt_count        = cnt_q;

endmodule
